// File: rtl/trafficgen.sv
// AXI4-Lite programmed AXI4-Stream packet generator: emits incrementing words in packets of LEN beats.
// Writes/reads take effect one cycle after the handshake; stream outputs hold while tready is low.
module trafficgen #(
  parameter int C_S00_AXI_DATA_WIDTH   = 32,
  parameter int C_S00_AXI_ADDR_WIDTH   = 4,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_START_COUNT = 32
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready
);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t      state;
  logic        enable;
  logic [15:0] len_reg;
  logic [31:0] pkt_cnt;
  logic [31:0] seq;
  logic [1:0]  aw_idx;
  logic [1:0]  ar_idx;
  logic [31:0] start_cnt;
  logic        start_done;
  logic [15:0] pkt_len;
  logic [15:0] beat;
  logic [15:0] len_eff;
  logic        aw_take;
  logic        wr_en;
  logic [C_S00_AXI_DATA_WIDTH-1:0] rd_mux;

  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_rresp  = 2'b00;
  assign m00_axis_tstrb = '1;

  assign start_done = (start_cnt == 32'(C_M00_AXIS_START_COUNT));
  assign len_eff    = (len_reg == 16'd0) ? 16'd1 : len_reg;
  assign aw_take    = ~s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid;
  assign wr_en      = s00_axi_awready & s00_axi_awvalid & s00_axi_wready & s00_axi_wvalid;

  logic unused_inputs;
  assign unused_inputs = ^{m00_axis_aclk, m00_axis_aresetn, s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr, s00_axi_araddr, s00_axi_wdata, s00_axi_wstrb};

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      aw_idx          <= 2'd0;
      enable          <= 1'b0;
      len_reg         <= 16'd0;
    end else begin
      s00_axi_awready <= aw_take;
      s00_axi_wready  <= aw_take;
      if (aw_take)
        aw_idx <= s00_axi_awaddr[3:2];
      if (wr_en)
        s00_axi_bvalid <= 1'b1;
      else if (s00_axi_bready)
        s00_axi_bvalid <= 1'b0;
      // PKTCNT and SEQ are read-only; writes there still complete with OKAY
      if (wr_en) begin
        case (aw_idx)
          2'd0: if (s00_axi_wstrb[0]) enable <= s00_axi_wdata[0];
          2'd1: begin
            if (s00_axi_wstrb[0]) len_reg[7:0]  <= s00_axi_wdata[7:0];
            if (s00_axi_wstrb[1]) len_reg[15:8] <= s00_axi_wdata[15:8];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ar_idx)
      2'd0:    rd_mux = {31'd0, enable};
      2'd1:    rd_mux = {16'd0, len_reg};
      2'd2:    rd_mux = pkt_cnt;
      default: rd_mux = seq;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      ar_idx          <= 2'd0;
    end else begin
      s00_axi_arready <= ~s00_axi_arready & s00_axi_arvalid & ~s00_axi_rvalid;
      if (~s00_axi_arready & s00_axi_arvalid & ~s00_axi_rvalid)
        ar_idx <= s00_axi_araddr[3:2];
      if (s00_axi_arready & s00_axi_arvalid) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_mux;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state           <= ST_IDLE;
      start_cnt       <= 32'd0;
      pkt_len         <= 16'd0;
      beat            <= 16'd0;
      seq             <= 32'd0;
      pkt_cnt         <= 32'd0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      if (!start_done)
        start_cnt <= start_cnt + 32'd1;
      case (state)
        ST_IDLE: begin
          if (start_done && enable) begin
            state           <= ST_SEND;
            pkt_len         <= len_eff;
            beat            <= 16'd0;
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= C_M00_AXIS_TDATA_WIDTH'(seq);
            m00_axis_tlast  <= (len_eff == 16'd1);
          end
        end
        default: begin
          if (m00_axis_tvalid && m00_axis_tready) begin
            seq            <= seq + 32'd1;
            m00_axis_tdata <= C_M00_AXIS_TDATA_WIDTH'(seq + 32'd1);
            if (m00_axis_tlast) begin
              pkt_cnt <= pkt_cnt + 32'd1;
              // enable only matters at packet boundaries; a new packet follows with no bubble
              if (enable) begin
                pkt_len        <= len_eff;
                beat           <= 16'd0;
                m00_axis_tlast <= (len_eff == 16'd1);
              end else begin
                state           <= ST_IDLE;
                m00_axis_tvalid <= 1'b0;
                m00_axis_tlast  <= 1'b0;
              end
            end else begin
              beat           <= beat + 16'd1;
              m00_axis_tlast <= (beat + 16'd1 == pkt_len - 16'd1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trafficgen.sv
// Directed bench for trafficgen: register access, startup delay, packet framing, stalls and enable/LEN changes.
module tb_trafficgen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, tready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, tvalid, tlast;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, tdata;
  logic [3:0]  tstrb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic rdy; logic vld; logic [31:0] dat; logic last; } vec_t;
  typedef struct { logic [3:0] addr; logic [31:0] exp; } rd_t;
  vec_t stall_tab[13];
  rd_t  rd_tab[3];

  trafficgen dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast), .m00_axis_tready(tready)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit ok = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; break; end
    end
    check("aw_handshake", 64'(ok), 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("awready_pulse", {awready, wready}, 0);
    check("bvalid", 64'(bvalid), 1);
    check("bresp", 64'(bresp), 0);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input string name, input logic [3:0] addr, input logic [31:0] exp);
    bit ok = 0;
    araddr = addr; arvalid = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    check("ar_handshake", 64'(ok), 1);
    @(posedge clk); #1;
    arvalid = 0;
    @(negedge clk);
    check("arready_pulse", 64'(arready), 0);
    check("rvalid", 64'(rvalid), 1);
    check(name, rdata, exp);
    check("rresp", 64'(rresp), 0);
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
    check("startup_reach", cyc, k);
  endtask

  initial begin
    stall_tab[0]  = '{1'b1, 1'b1, 32'd24, 1'b0};
    stall_tab[1]  = '{1'b1, 1'b1, 32'd25, 1'b0};
    stall_tab[2]  = '{1'b0, 1'b1, 32'd26, 1'b0};
    stall_tab[3]  = '{1'b0, 1'b1, 32'd26, 1'b0};
    stall_tab[4]  = '{1'b1, 1'b1, 32'd26, 1'b0};
    stall_tab[5]  = '{1'b1, 1'b1, 32'd27, 1'b0};
    stall_tab[6]  = '{1'b1, 1'b1, 32'd28, 1'b0};
    stall_tab[7]  = '{1'b1, 1'b1, 32'd29, 1'b0};
    stall_tab[8]  = '{1'b1, 1'b1, 32'd30, 1'b0};
    stall_tab[9]  = '{1'b0, 1'b1, 32'd31, 1'b1};
    stall_tab[10] = '{1'b0, 1'b1, 32'd31, 1'b1};
    stall_tab[11] = '{1'b1, 1'b1, 32'd31, 1'b1};
    stall_tab[12] = '{1'b0, 1'b1, 32'd32, 1'b0};
    rd_tab[0] = '{4'h0, 32'd1};
    rd_tab[1] = '{4'h4, 32'd8};
    rd_tab[2] = '{4'h0, 32'd1};

    // reset values
    #15;
    check("reset_ctrl_outs", {awready, wready, bvalid, arready, rvalid, tvalid, tlast}, 0);
    check("reset_rdata", rdata, 0);
    check("reset_tdata", tdata, 0);
    check("tstrb", 64'(tstrb), 4'hF);
    @(negedge clk); rst_n = 1;

    // configure, then hold tready low through the startup window
    axi_write(4'h0, 32'd1, 4'hF);
    axi_write(4'h4, 32'd8, 4'hF);
    wait_cyc(32);
    check("tvalid_before_start", 64'(tvalid), 0);
    @(negedge clk);
    check("first_beat", {tvalid, tdata, tlast}, {1'b1, 32'd0, 1'b0});
    repeat (3) @(negedge clk);
    check("stalled_hold", {tvalid, tdata, tlast}, {1'b1, 32'd0, 1'b0});

    for (int i = 0; i < 3; i++) axi_read("rd_cfg", rd_tab[i].addr, rd_tab[i].exp);

    // continuous streaming: three 8-beat packets
    @(negedge clk); tready = 1;
    for (int n = 0; n < 24; n++) begin
      check("stream_beat", {tvalid, tdata, tlast}, {1'b1, 32'(n), (n % 8) == 7});
      @(negedge clk);
    end
    tready = 0;
    axi_read("pktcnt_3", 4'h8, 32'd3);
    axi_read("seq_24", 4'hC, 32'd24);

    // stalls inside a packet and across its last beat
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      tready = stall_tab[i].rdy;
      check("stall_vec", {tvalid, tdata, tlast}, {stall_tab[i].vld, stall_tab[i].dat, stall_tab[i].last});
      @(negedge clk);
    end
    tready = 0;

    // disable mid-packet: packet 32..39 must complete
    tready = 1;
    for (int n = 0; n < 3; n++) begin
      check("pre_disable", {tvalid, tdata, tlast}, {1'b1, 32'(32 + n), 1'b0});
      @(negedge clk);
    end
    tready = 0;
    axi_write(4'h0, 32'd0, 4'hF);
    @(negedge clk); tready = 1;
    for (int n = 0; n < 5; n++) begin
      check("drain_beat", {tvalid, tdata, tlast}, {1'b1, 32'(35 + n), n == 4});
      @(negedge clk);
    end
    check("stopped_after_last", {tvalid, tlast}, 0);
    repeat (3) @(negedge clk);
    check("stays_stopped", 64'(tvalid), 0);
    tready = 0;
    axi_read("pktcnt_5", 4'h8, 32'd5);
    axi_read("seq_40", 4'hC, 32'd40);

    // LEN=0 behaves as single-beat packets; resume continues the sequence
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h0, 32'd1, 4'hF);
    @(negedge clk); tready = 1;
    for (int n = 0; n < 4; n++) begin
      check("len0_beat", {tvalid, tdata, tlast}, {1'b1, 32'(40 + n), 1'b1});
      @(negedge clk);
    end
    tready = 0;
    axi_read("pktcnt_9", 4'h8, 32'd9);
    axi_read("len_raw0", 4'h4, 32'd0);

    // reset mid-packet
    @(negedge clk); #2 rst_n = 0; #1;
    check("reset_mid_pkt", {tvalid, tdata, tlast}, 0);
    @(negedge clk); rst_n = 1;
    axi_write(4'h0, 32'd1, 4'hF);
    axi_read("seq_after_rst", 4'hC, 32'd0);
    wait_cyc(32);
    check("restart_hold", 64'(tvalid), 0);
    @(negedge clk);
    check("restart_beat", {tvalid, tdata}, {1'b1, 32'd0});

    // byte strobes and read-only registers
    axi_write(4'h4, 32'h0000_1234, 4'hF);
    axi_write(4'h4, 32'h0000_ABCD, 4'b0001);
    axi_read("len_strobe", 4'h4, 32'h0000_12CD);
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF);
    axi_read("pktcnt_ro", 4'h8, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trafficgen.md
Name: trafficgen

Overview:
AXI4-Lite-configured AXI4-Stream traffic generator. A host programs an enable bit and a packet length through a 4-register AXI4-Lite slave. The block then emits back-to-back packets of incrementing 32-bit words on an AXI4-Stream master, with tlast on the final beat of each packet. It is used as a synthetic stimulus source in front of stream consumers.

Parameters:
C_S00_AXI_DATA_WIDTH, 32, AXI-Lite data width (only 32 supported)
C_S00_AXI_ADDR_WIDTH, 4, AXI-Lite byte address width (4 word registers)
C_M00_AXIS_TDATA_WIDTH, 32, stream data width
C_M00_AXIS_START_COUNT, 32, idle clock cycles after reset release before streaming is permitted

Ports:
s00_axi_aclk  in  1  the single clock; all logic is clocked on its rising edge
s00_axi_aresetn  in  1  reset, asynchronous, active-low
m00_axis_aclk  in  1  must be tied to s00_axi_aclk; unused internally
m00_axis_aresetn  in  1  must be tied to s00_axi_aresetn; unused internally
s00_axi_awaddr  in  ADDR_W  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte strobes
s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake
s00_axi_bresp  out  2  always 00 (OKAY)
s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake
s00_axi_araddr  in  ADDR_W  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  always 00
s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake
m00_axis_tvalid  out  1  stream valid
m00_axis_tdata  out  TDATA_W  stream data
m00_axis_tstrb  out  TDATA_W/8  always all ones
m00_axis_tlast  out  1  last beat of packet
m00_axis_tready  in  1  stream ready

Behaviour:
- Reset (async, aresetn=0): all registers, counters and outputs are 0. This includes awready, wready, bvalid, arready, rvalid, rdata, tvalid, tdata and tlast.
- Register map (word index = addr[3:2]):
  - 0x0 CTRL RW: bit0 = enable.
  - 0x4 LEN RW: bits[15:0] = packet length in beats; a value of 0 is treated as 1.
  - 0x8 PKTCNT RO: number of completed packets (32-bit, wraps).
  - 0xC SEQ RO: next tdata value.
  - Writes to RO registers are ignored but still return OKAY. Only byte lanes with wstrb=1 are written.
- AXI-Lite write path:
  - awready and wready pulse high together for exactly 1 cycle when awvalid and wvalid are both high and awready is 0. The register updates on that edge.
  - bvalid rises the next cycle and is held until bready=1.
  - No new write is accepted while bvalid=1.
- AXI-Lite read path:
  - arready pulses for 1 cycle when arvalid=1, arready=0 and rvalid=0; the address is latched.
  - rvalid and rdata are registered the next cycle. rvalid is held until rready=1.
- Startup: a counter counts C_M00_AXIS_START_COUNT cycles after reset release. Until it completes, tvalid stays 0 regardless of enable.
- Stream FSM states IDLE and SEND:
  - IDLE -> SEND when startup is done and enable=1. On entry, LEN is latched into the packet length, the beat index is cleared, and tvalid is registered high the next cycle.
  - In SEND, tdata = SEQ and tlast = (beat index == latched length - 1).
  - A beat transfers when tvalid & tready: SEQ increments (32-bit wrap) and the beat index increments.
  - While tready=0, tvalid, tdata and tlast hold their values.
  - When a tlast beat transfers: PKTCNT increments. If enable=1, a new packet starts back-to-back with LEN re-latched and no bubble. Otherwise the FSM returns to IDLE and tvalid drops.
- Clearing enable mid-packet does not truncate the packet; it stops at the next packet boundary.
- Changing LEN mid-packet affects only the next packet.
- Asserting reset mid-packet drops tvalid immediately and restarts the startup count.

Test Plan:
- Reset, then write CTRL=1 and LEN=8. Hold tready=0 -> tvalid rises only after 32 cycles; tdata=0 holds while stalled; bresp=00 on both writes.
- Read 0x0, 0x4, 0x0 -> rdata = 1, 8, 1, each with rresp=00 and a one-cycle arready pulse.
- Raise tready continuously -> tdata sequence 0,1,2,...; tlast on values 7, 15, 23; PKTCNT reads 3 after 24 beats.
- Drop tready for 2 cycles mid-packet -> tvalid, tdata and tlast are held, with no data skipped or duplicated.
- Write CTRL=0 mid-packet -> the packet completes through its tlast, then tvalid=0. Write CTRL=1 -> streaming resumes with the next SEQ value.
- Write LEN=0 -> every beat has tlast=1.
